// File: rtl/giraffe_uart_pkg.sv
// Shared definitions for the giraffe UART transmitter: state encoding and default baud divisor.
package giraffe_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/giraffe_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module giraffe_baud_cnt
    import giraffe_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clear || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/giraffe_uart_tx.sv
// Serial transmitter: start bit, N_data bits LSB first, optional even parity, one stop bit.
// state  | meaning
// IDLE   | line high, uart_rdy high, waiting for wreq
// START  | driving the start bit (0)
// DATA   | shifting out data bits LSB first
// PARITY | driving even parity of the captured word
// STOP   | driving the stop bit (1); tx_done on exit
module giraffe_uart_tx
    import giraffe_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int N_data       = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wreq,
    input  logic [N_data-1:0] wdata,
    output logic              uart_rdy,
    output logic              tx,
    output logic              tx_done
);

    localparam int IDX_W = (N_data > 1) ? $clog2(N_data) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_data - 1);

    uart_state_t       state;
    logic [N_data-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              par_bit;
    logic              bit_end;

    // The timer is held at zero while idle so the accepting edge starts a full start bit.
    giraffe_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (state == IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            uart_rdy <= 1'b1;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            par_bit  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wreq && uart_rdy) begin
                        shreg    <= wdata;
                        par_bit  <= ^wdata;
                        state    <= START;
                        tx       <= 1'b0;
                        uart_rdy <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        tx       <= 1'b1;
                        tx_done  <= 1'b1;
                        uart_rdy <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    uart_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/giraffe_uart_tx.md
GIRAFFE_UART_TX -- requirements
Module: giraffe_uart_tx

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide N_data, 8, width of wdata; frame data bits.
REQ-003 SHALL provide PARITY_EN, 0, 0 = no parity bit, 1 = even parity bit after data.

Ports (name, direction, width, meaning):
REQ-004 SHALL provide clk, input, 1, single clock; all logic on posedge clk.
REQ-005 SHALL provide nrst, input, 1, reset; synchronous, active-low.
REQ-006 SHALL provide wreq, input, 1, write request from the ADC framing FSM; sampled only when uart_rdy = 1.
REQ-007 SHALL provide wdata, input, N_data, byte to transmit; captured on an accepted wreq.
REQ-008 SHALL provide uart_rdy, output, 1, high only when idle and able to accept a byte.
REQ-009 SHALL provide tx, output, 1, serial line; idle high.
REQ-010 SHALL provide tx_done, output, 1, one-cycle pulse at end of stop bit.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN = 1.
REQ-012 SHALL accept a byte at a posedge where wreq = 1 and uart_rdy = 1. At that edge: capture wdata into shift register, state -> START, tx -> 0, uart_rdy -> 0.
REQ-013 SHALL ignore wreq while uart_rdy = 0. No queuing; the in-flight frame is unaffected.
REQ-014 SHALL hold each bit (start, data, parity, stop) on tx for exactly CLKS_PER_BIT cycles. Timing uses a baud counter counting 0..CLKS_PER_BIT-1, reset to 0 at each bit boundary.
REQ-015 SHALL send data LSB first: bit index 0..N_data-1, then PARITY (if enabled), then STOP.
REQ-016 SHALL drive the PARITY bit as the XOR of the captured data, so the total count of 1s in data plus parity is even.
REQ-017 SHALL drive tx = 1 during STOP.
REQ-018 SHALL, on the last STOP cycle:
- pulse tx_done = 1 for one cycle;
- state -> IDLE;
- set uart_rdy = 1 from the next cycle.
REQ-019 SHALL give a frame length, from accepting edge to uart_rdy reassertion, of (N_data+2+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-020 SHALL support back-to-back frames. A wreq in the first cycle uart_rdy = 1 is accepted, and the next start bit begins with no extra idle bit.
REQ-021 SHALL register uart_rdy, tx and tx_done. No combinational path from wreq or wdata to any output.
REQ-022 SHALL ignore wdata changes after capture.

Reset
REQ-023 SHALL take reset only on posedge clk while nrst = 0.
REQ-024 SHALL set on reset: state = IDLE, tx = 1, uart_rdy = 1, tx_done = 0, baud counter = 0, bit index = 0, shift register = 0.
REQ-025 SHALL, on reset mid-frame, abort the frame immediately. tx returns high on the reset edge, no tx_done is generated, and the next accepted byte starts a clean frame.
REQ-026 SHALL ignore wreq while nrst = 0.

Structure
REQ-027 SHALL place in shared package giraffe_uart_pkg:
- the state encoding constants (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4; 3-bit);
- the default CLKS_PER_BIT.
REQ-028 SHALL use one sub-module giraffe_baud_cnt. It is parameterised by CLKS_PER_BIT, has inputs clk, nrst and clear, and output bit_end, a pulse on count = CLKS_PER_BIT-1.
REQ-029 SHALL keep all other logic (FSM, shift register, bit index, parity) in giraffe_uart_tx.

Verification
REQ-030 SHALL cover a basic frame. CLKS_PER_BIT = 4, PARITY_EN = 0, wreq pulse with wdata = 0xC5 -> tx per 4-cycle bit: 0,1,0,1,0,0,0,1,1,1; tx_done pulse at cycle 40; uart_rdy low for 40 cycles.
REQ-031 SHALL cover parity. PARITY_EN = 1, wdata = 0xC5 -> parity bit 0; wdata = 0xC4 -> parity bit 1; frame of 44 cycles.
REQ-032 SHALL cover a busy request. wreq = 1 with 0x3A at cycle 10 of a 0xC5 frame -> no effect; only 0xC5 is serialised.
REQ-033 SHALL cover back-to-back frames. wreq with 0xFF held for the first uart_rdy = 1 cycle, then 0x00 -> two contiguous frames of 40 cycles each, 80 cycles total with no idle gap.
REQ-034 SHALL cover reset mid-frame. nrst = 0 for 1 cycle at cycle 17 -> tx = 1 and uart_rdy = 1 after that edge, no tx_done; next wreq with 0x81 produces a correct frame.
REQ-035 SHALL cover minimum baud. CLKS_PER_BIT = 2, wdata = 0xA5 -> each bit exactly 2 cycles; frame of 20 cycles.
